robo_atuador: RTL
=================

# robo_atuador

Wheel actuator driver at the receiving end of the wall-following controller's command interface. It consumes the `avancar`/`girar` command pair and turns each accepted command into a fixed burst of step pulses on the left and right wheel motors, with direction lines. It reports `ocupado`, `concluido` and `erro` back to the controller side.

## Interface
- `PASSOS_AVANCO`, default 8: step pulses per forward command; must be ≥1.
- `PASSOS_GIRO`, default 4: step pulses per rotate command; must be ≥1.
- `DIV_PASSO`, default 4: clock cycles per step period; must be ≥2.
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `avancar`  in  1  forward command from the controller.
- `girar`  in  1  rotate command from the controller.
- `passo_esq`  out  1  left wheel step pulse.
- `passo_dir`  out  1  right wheel step pulse.
- `sentido_esq`  out  1  left wheel direction: 1 = forward, 0 = reverse.
- `sentido_dir`  out  1  right wheel direction: 1 = forward, 0 = reverse.
- `ocupado`  out  1  a command is executing; new commands are ignored.
- `concluido`  out  1  one-cycle pulse when a command finishes.
- `erro`  out  1  one-cycle pulse when a conflicting command is rejected.

## Operation
- The FSM is Moore and has four states:
  - OCIOSO (reset state).
  - AVANCANDO.
  - GIRANDO.
  - PAUSA.
- OCIOSO samples the command every cycle:
  - `{avancar,girar}`=10 → AVANCANDO.
  - 01 → GIRANDO.
  - 11 → stay in OCIOSO, assert `erro` for the next cycle, drop the command.
  - 00 → stay in OCIOSO.
- On acceptance, the divider counter `div` and the step counter `cnt` load 0.
- AVANCANDO and GIRANDO, every cycle:
  - `div` increments.
  - When `div`==DIV_PASSO-1, both `passo_*` are high for that cycle, `div` wraps to 0 and `cnt` increments.
  - When `cnt`==N-1 and `div`==DIV_PASSO-1, the next state is PAUSA. N is PASSOS_AVANCO or PASSOS_GIRO.
- PAUSA lasts one cycle: `concluido`=1, `ocupado`=1. It then goes to OCIOSO.
- Direction outputs:
  - AVANCANDO: `sentido_esq`=1, `sentido_dir`=1.
  - GIRANDO: `sentido_esq`=1, `sentido_dir`=0 (turns right, away from a head obstacle).
  - OCIOSO and PAUSA: both 0.
- `ocupado`=1 in AVANCANDO, GIRANDO and PAUSA.
- Command inputs are don't-care outside OCIOSO. A command held high across completion is accepted again on the first OCIOSO cycle.
- Counter widths are `$clog2(max(PASSOS_AVANCO,PASSOS_GIRO)+1)` and `$clog2(DIV_PASSO)`. Counters never wrap mid-command.

## Timing
- Reset value of every output is 0. `reset` low forces OCIOSO and zeroes the counters immediately, mid-burst included; a partial burst is abandoned with no `concluido`.
- Acceptance edge is T0. `ocupado` rises in cycle T0+1.
- Step k (1..N) pulses in cycle T0+k·DIV_PASSO.
- `concluido` is in cycle T0+N·DIV_PASSO+1.
- The earliest next acceptance is at the end of cycle T0+N·DIV_PASSO+2.
- Each step pulse is exactly one cycle wide, followed by at least DIV_PASSO-1 low cycles.
- Direction outputs are stable from T0+1 through the last pulse cycle, and are set at least DIV_PASSO-1 cycles before the first pulse.
- `erro` is high in the cycle after a 11 sample in OCIOSO. A sustained 11 gives `erro` high every cycle.

## Configuration
- `ROBO_ATUADOR_RAMPA_EN` defined: the first step period of each command is 2·DIV_PASSO cycles (soft start). Step 1 is at T0+2·DIV_PASSO; step k for k≥2 is at T0+(k+1)·DIV_PASSO; `concluido` is at T0+(N+1)·DIV_PASSO+1.
- Macro undefined: uniform periods as specified above.

## Structure
- Package `robo_pkg` holds:
  - the state typedef (OCIOSO=2'b00, AVANCANDO=2'b01, GIRANDO=2'b10, PAUSA=2'b11);
  - direction constants (FRENTE=1, RE=0).
- Sub-module `gerador_passo` holds the divider, the step counter and the ramp logic. Inputs: start, N. Outputs: pulse, last. The top level owns the FSM and the direction/status outputs.

## Test plan
- Defaults, `avancar`=1 for one cycle at T0:
  - 8 pulses on both wheels at T0+4, 8, …, 32;
  - `sentido_*`=1/1;
  - `concluido` at T0+33;
  - `ocupado` high from T0+1 to T0+33.
- `girar` pulse: 4 pulses at T0+4…16, `sentido_esq`=1, `sentido_dir`=0, `concluido` at T0+17.
- `avancar`=`girar`=1 in OCIOSO: `erro`=1 for one cycle, no pulses, `ocupado` stays 0.
- `girar` toggled during an AVANCANDO burst: ignored, burst completes unchanged.
- `reset` low after step 3 of a forward burst: all outputs go to 0 asynchronously, no `concluido`. After release, a new `avancar` gives a full 8-step burst.
- `ROBO_ATUADOR_RAMPA_EN` defined, `avancar` at T0: pulses at T0+8, 12, …, 36; `concluido` at T0+37.

Source files
------------

// File: rtl/robo_pkg.sv
// ---------------------------------------------------------------------------
// robo_pkg
// Shared definitions for the wheel actuator driver (robo_atuador).
//   estado_t     : actuator FSM states (OCIOSO, AVANCANDO, GIRANDO, PAUSA)
//   FRENTE / RE  : wheel direction line values (forward / reverse)
//   max_int      : elaboration-time maximum, used to size the step counter
// ---------------------------------------------------------------------------
package robo_pkg;

   typedef enum logic [1:0] {
      OCIOSO    = 2'b00,
      AVANCANDO = 2'b01,
      GIRANDO   = 2'b10,
      PAUSA     = 2'b11
   } estado_t;

   localparam logic FRENTE = 1'b1;
   localparam logic RE     = 1'b0;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gerador_passo.sv
// ---------------------------------------------------------------------------
// gerador_passo
// Step pulse generator: a clock divider plus a step counter. A burst is
// started by i_start (both counters load 0) and advances while i_ativo is
// high, producing one single-cycle pulse every DIV_PASSO cycles.
// Optional feature (macro ROBO_ATUADOR_RAMPA_EN): soft start, the first
// step period of each burst lasts 2*DIV_PASSO cycles.
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous active-low reset
//   i_start   in   load both counters with 0 (command accepted)
//   i_ativo   in   burst in progress, counters advance
//   i_n       in   number of steps of the current burst (>= 1)
//   o_pulso   out  step pulse, one cycle wide
//   o_ultimo  out  high together with the pulse of step N
// ---------------------------------------------------------------------------
module gerador_passo
   import robo_pkg::*;
#(
   parameter int DIV_PASSO = 4,
   parameter int CW        = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_start,
   input  logic          i_ativo,
   input  logic [CW-1:0] i_n,
   output logic          o_pulso,
   output logic          o_ultimo
);

   localparam int            DW      = $clog2(DIV_PASSO);
   localparam logic [DW-1:0] DIV_MAX = DW'(DIV_PASSO - 1);

   logic [DW-1:0] r_div;
   logic [CW-1:0] r_cnt;
   logic          w_fimPeriodo;
   logic          w_pulso;

   assign w_fimPeriodo = (r_div == DIV_MAX);

   // Divider wraps at the end of every period; the step counter only
   // counts periods that actually emitted a pulse, so a soft-start period
   // does not consume a step and the counter stops at N when the burst ends.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_div <= '0;
         r_cnt <= '0;
      end else if (i_start) begin
         r_div <= '0;
         r_cnt <= '0;
      end else if (i_ativo) begin
         if (w_fimPeriodo) begin
            r_div <= '0;
            if (w_pulso)
               r_cnt <= r_cnt + CW'(1);
         end else begin
            r_div <= r_div + DW'(1);
         end
      end
   end

`ifdef ROBO_ATUADOR_RAMPA_EN
   logic r_rampa;

   // Soft start: the first divider period of a burst is swallowed, which
   // stretches the first step period to twice its nominal length.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_rampa <= 1'b0;
      else if (i_start)
         r_rampa <= 1'b1;
      else if (i_ativo && w_fimPeriodo)
         r_rampa <= 1'b0;
   end

   assign w_pulso = i_ativo && w_fimPeriodo && !r_rampa;
`else
   assign w_pulso = i_ativo && w_fimPeriodo;
`endif

   assign o_pulso  = w_pulso;
   assign o_ultimo = w_pulso && (r_cnt == (i_n - CW'(1)));

endmodule

// File: rtl/robo_atuador.sv
// ---------------------------------------------------------------------------
// robo_atuador
// Wheel actuator driver. Accepts avancar/girar commands while idle and turns
// each into a fixed burst of step pulses on both wheels with direction lines,
// reporting ocupado, concluido and erro back to the controller.
// Optional feature (macro ROBO_ATUADOR_RAMPA_EN, implemented in
// gerador_passo): soft start, first step period doubled.
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   avancar      in   forward command
//   girar        in   rotate command
//   passo_esq    out  left wheel step pulse
//   passo_dir    out  right wheel step pulse
//   sentido_esq  out  left wheel direction (1 = forward)
//   sentido_dir  out  right wheel direction (1 = forward)
//   ocupado      out  command executing, new commands ignored
//   concluido    out  one-cycle pulse when a command finishes
//   erro         out  one-cycle pulse per rejected conflicting command
// ---------------------------------------------------------------------------
module robo_atuador
   import robo_pkg::*;
#(
   parameter int PASSOS_AVANCO = 8,
   parameter int PASSOS_GIRO   = 4,
   parameter int DIV_PASSO     = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic avancar,
   input  logic girar,
   output logic passo_esq,
   output logic passo_dir,
   output logic sentido_esq,
   output logic sentido_dir,
   output logic ocupado,
   output logic concluido,
   output logic erro
);

   localparam int CW = $clog2(max_int(PASSOS_AVANCO, PASSOS_GIRO) + 1);

   estado_t       r_estado;
   estado_t       w_prox;
   logic          r_erro;
   logic          w_start;
   logic          w_ativo;
   logic          w_pulso;
   logic          w_ultimo;
   logic [CW-1:0] w_n;

   assign w_ativo = (r_estado == AVANCANDO) || (r_estado == GIRANDO);
   assign w_n     = (r_estado == GIRANDO) ? CW'(PASSOS_GIRO) : CW'(PASSOS_AVANCO);

   gerador_passo #(
      .DIV_PASSO (DIV_PASSO),
      .CW        (CW)
   ) u_gerador (
      .clock    (clock),
      .reset    (reset),
      .i_start  (w_start),
      .i_ativo  (w_ativo),
      .i_n      (w_n),
      .o_pulso  (w_pulso),
      .o_ultimo (w_ultimo)
   );

   // State register. The error flag is registered so that a conflicting
   // sample shows up as erro in the following cycle, once per 11 sample.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_estado <= OCIOSO;
         r_erro   <= 1'b0;
      end else begin
         r_estado <= w_prox;
         r_erro   <= (r_estado == OCIOSO) && avancar && girar;
      end
   end

   // Next state and Moore outputs. Commands are only looked at in OCIOSO;
   // a conflicting pair is dropped without leaving the idle state.
   always_comb begin
      w_prox      = r_estado;
      w_start     = 1'b0;
      sentido_esq = RE;
      sentido_dir = RE;
      ocupado     = 1'b0;
      concluido   = 1'b0;
      case (r_estado)
         OCIOSO: begin
            if (avancar && !girar) begin
               w_prox  = AVANCANDO;
               w_start = 1'b1;
            end else if (girar && !avancar) begin
               w_prox  = GIRANDO;
               w_start = 1'b1;
            end
         end
         AVANCANDO: begin
            sentido_esq = FRENTE;
            sentido_dir = FRENTE;
            ocupado     = 1'b1;
            if (w_ultimo)
               w_prox = PAUSA;
         end
         GIRANDO: begin
            sentido_esq = FRENTE;
            sentido_dir = RE;
            ocupado     = 1'b1;
            if (w_ultimo)
               w_prox = PAUSA;
         end
         PAUSA: begin
            ocupado   = 1'b1;
            concluido = 1'b1;
            w_prox    = OCIOSO;
         end
         default: w_prox = OCIOSO;
      endcase
   end

   assign passo_esq = w_pulso;
   assign passo_dir = w_pulso;
   assign erro      = r_erro;

endmodule
